// File: rtl/gain_pkg.sv
// -----------------------------------------------------------------------------
// gain_pkg
//
// Shared helpers for the gain_stream fixed-point gain stage:
//   unity_gain() - fixed-point encoding of a gain of 1.0 for a given FRAC_W
//   ch_width()   - channel-index width, max(1, clog2(nch))
//   sat_resize() - clamp a wide signed value into a data_w-bit signed range
// -----------------------------------------------------------------------------
package gain_pkg;

    // Width of the scratch value handed to sat_resize(); wide enough for any
    // realistic DATA_W + GAIN_W product.
    localparam int SAT_W = 64;

    // Gain of exactly 1.0 in unsigned Q(GAIN_W-FRAC_W).FRAC_W.
    function automatic int unity_gain(input int frac_w);
        return 1 << frac_w;
    endfunction

    // A single-channel stream still carries a 1-bit channel index so that
    // the port never collapses to zero width.
    function automatic int ch_width(input int nch);
        int w;
        w = 0;
        while (((1 << w) < nch) && (w < 31)) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Clamp to [-2^(data_w-1), 2^(data_w-1)-1]; the caller keeps the low
    // data_w bits of the result.
    function automatic logic signed [SAT_W-1:0] sat_resize(
        input logic signed [SAT_W-1:0] value,
        input int                      data_w
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (data_w - 1));
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/gain_stream_ramp.sv
// -----------------------------------------------------------------------------
// gain_stream_ramp
//
// Holds the applied (current) gain and the target gain. The current gain moves
// toward the target by at most one step per frame end, so gain changes never
// produce a step discontinuity unless step is zero (immediate jump).
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   gain_load_i    one-cycle pulse: latch gain_target_i as the new target
//   gain_target_i  new target gain
//   step_i         per-frame ramp step, 0 = jump straight to the target
//   frame_end_i    last channel of a frame was accepted this cycle
//   cur_gain_o     gain applied to samples accepted this cycle
//   ramping_o      current gain differs from target gain
// -----------------------------------------------------------------------------
module gain_stream_ramp
    import gain_pkg::*;
#(
    parameter int GAIN_W = 8,
    parameter int FRAC_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              gain_load_i,
    input  logic [GAIN_W-1:0] gain_target_i,
    input  logic [GAIN_W-1:0] step_i,
    input  logic              frame_end_i,
    output logic [GAIN_W-1:0] cur_gain_o,
    output logic              ramping_o
);

    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(FRAC_W));

    logic [GAIN_W-1:0] cur_q;
    logic [GAIN_W-1:0] cur_d;
    logic [GAIN_W-1:0] tgt_q;
    logic [GAIN_W-1:0] tgt_d;

    // One extra headroom bit so differences and comparisons never wrap.
    logic [GAIN_W:0] cur_w;
    logic [GAIN_W:0] tgt_w;
    logic [GAIN_W:0] step_w;

    assign cur_w  = {1'b0, cur_q};
    assign tgt_w  = {1'b0, tgt_q};
    assign step_w = {1'b0, step_i};

    // A load arriving together with a frame end only takes effect from the
    // next frame: the ramp below always reads the registered target.
    assign tgt_d = gain_load_i ? gain_target_i : tgt_q;

    always_comb begin
        // NOTE: default assignment first so every path drives cur_d and no
        // latch is inferred.
        cur_d = cur_q;
        if (frame_end_i) begin
            if (step_i == '0) begin
                cur_d = tgt_q;
            end else if (cur_w < tgt_w) begin
                // Step would reach or pass the target: land exactly on it.
                cur_d = (step_w >= (tgt_w - cur_w)) ? tgt_q : (cur_q + step_i);
            end else if (cur_w > tgt_w) begin
                cur_d = (step_w >= (cur_w - tgt_w)) ? tgt_q : (cur_q - step_i);
            end
        end
    end

    // NOTE: non-blocking assignments for all clocked state so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q <= UNITY;
            tgt_q <= UNITY;
        end else begin
            cur_q <= cur_d;
            tgt_q <= tgt_d;
        end
    end

    assign cur_gain_o = cur_q;
    assign ramping_o  = (cur_q != tgt_q);

endmodule

// File: rtl/gain_stream.sv
// -----------------------------------------------------------------------------
// gain_stream
//
// Multi-channel fixed-point gain stage on a valid/ready stream. Signed TDM
// samples are multiplied by an unsigned gain (FRAC_W fractional bits), rounded
// half toward +inf and reduced back to DATA_W bits. Two pipeline stages give a
// 2-cycle latency at 1 sample/cycle; a downstream stall freezes both stages.
//
// Configuration macro:
//   GAIN_STREAM_SATURATE_EN  defined   -> clamp result to the DATA_W range
//                            undefined -> keep the low DATA_W bits (wrap)
//
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_valid, o_ready  input handshake (o_ready is combinational)
//   i_ch, i_data      channel index and signed sample in
//   o_valid, i_ready  output handshake
//   o_ch, o_data      channel index and scaled sample out
//   i_gain_load       one-cycle pulse latching i_gain_target
//   i_gain_target     new target gain
//   i_step            per-frame ramp step (0 = jump)
//   o_gain            currently applied gain
//   o_ramping         applied gain differs from target
// -----------------------------------------------------------------------------
module gain_stream
    import gain_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAIN_W = 8,
    parameter int FRAC_W = 6,
    parameter int NCH    = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [ch_width(NCH)-1:0]   i_ch,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [ch_width(NCH)-1:0]   o_ch,
    output logic [DATA_W-1:0]          o_data,
    input  logic                       i_gain_load,
    input  logic [GAIN_W-1:0]          i_gain_target,
    input  logic [GAIN_W-1:0]          i_step,
    output logic [GAIN_W-1:0]          o_gain,
    output logic                       o_ramping
);

    localparam int CH_W   = ch_width(NCH);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    // One guard bit so adding the rounding bias cannot overflow the product.
    localparam int RND_W  = PROD_W + 1;
    localparam logic signed [RND_W-1:0] RND_BIAS = RND_W'(unity_gain(FRAC_W) >> 1);

    // ---------------------------------------------------------------- control
    logic en;
    logic in_xfer;
    logic frame_end;

    logic              s1_valid_q;
    logic [CH_W-1:0]   s1_ch_q;
    logic signed [PROD_W-1:0] s1_prod_q;

    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [DATA_W-1:0] out_data_q;

    logic [GAIN_W-1:0] cur_gain;

    // The whole pipeline advances unless the output holds a sample that the
    // downstream side refuses this cycle.
    assign en        = !out_valid_q || i_ready;
    assign in_xfer   = i_valid && en;
    // Out-of-range channel indices are scaled but never close a frame.
    assign frame_end = in_xfer && (i_ch == CH_W'(NCH - 1));

    // ------------------------------------------------------------ gain ramp
    gain_stream_ramp #(
        .GAIN_W (GAIN_W),
        .FRAC_W (FRAC_W)
    ) u_ramp (
        .clk_i         (i_clk),
        .rst_ni        (i_reset_n),
        .gain_load_i   (i_gain_load),
        .gain_target_i (i_gain_target),
        .step_i        (i_step),
        .frame_end_i   (frame_end),
        .cur_gain_o    (cur_gain),
        .ramping_o     (o_ramping)
    );

    // ---------------------------------------------------- stage 1: multiply
    logic signed [DATA_W-1:0] data_s;
    logic signed [GAIN_W:0]   gain_s;
    logic signed [PROD_W-1:0] prod_d;

    assign data_s = $signed(i_data);
    // Zero-extended so the unsigned gain is treated as positive.
    assign gain_s = $signed({1'b0, cur_gain});
    assign prod_d = PROD_W'(data_s) * PROD_W'(gain_s);

    // ------------------------------------------- stage 2: round and resize
    logic signed [RND_W-1:0]  sum;
    logic signed [RND_W-1:0]  rounded;
    logic [DATA_W-1:0]        data_d;

    assign sum     = RND_W'(s1_prod_q) + RND_BIAS;
    // Arithmetic shift floors, so bias-then-floor rounds half toward +inf.
    assign rounded = sum >>> FRAC_W;

`ifdef GAIN_STREAM_SATURATE_EN
    assign data_d = DATA_W'(sat_resize(SAT_W'(rounded), DATA_W));
`else
    assign data_d = DATA_W'(rounded);
`endif

    // --------------------------------------------------- pipeline registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: payload registers are reset as well as the valids, since
            // o_data and o_ch must read zero straight out of reset.
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_prod_q   <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else if (en) begin
            s1_valid_q <= in_xfer;
            if (in_xfer) begin
                s1_ch_q   <= i_ch;
                s1_prod_q <= prod_d;
            end
            out_valid_q <= s1_valid_q;
            // Bubbles leave o_data/o_ch at their last value.
            if (s1_valid_q) begin
                out_ch_q   <= s1_ch_q;
                out_data_q <= data_d;
            end
        end
    end

    assign o_ready = en;
    assign o_valid = out_valid_q;
    assign o_ch    = out_ch_q;
    assign o_data  = out_data_q;
    assign o_gain  = cur_gain;

endmodule
